// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one multi-cycle data memory between two requesters.
// Latency: grant on the edge that samples req; done one edge after mem_ready is sampled (min 2 cycles).
// Backpressure: requesters hold req until done; the command stays on the memory until mem_ready or timeout.
module dmem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64   // legal range 2..255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_done,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_done,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          busy,
   output logic          timeout_err
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       prio;
   logic       owner;
   logic [7:0] cnt;

   logic       p0_elig, p1_elig;
   logic       grant, winner;
   logic       complete, abort;

   // A port whose done pulse is showing cannot win, so a held req never double-issues.
   assign p0_elig = p0_req & ~p0_done;
   assign p1_elig = p1_req & ~p1_done;
   assign busy    = (state == WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      winner    = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (p0_elig || p1_elig) begin
               grant     = 1'b1;
               winner    = (p0_elig && p1_elig) ? prio : p1_elig;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // Completion takes precedence over a timeout landing on the same edge.
            if (mem_ready) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio        <= 1'b0;
         owner       <= 1'b0;
         cnt         <= 8'd0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         p0_rdata    <= '0;
         p1_rdata    <= '0;
         p0_done     <= 1'b0;
         p1_done     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         p0_done <= 1'b0;
         p1_done <= 1'b0;
         if (grant) begin
            owner     <= winner;
            cnt       <= 8'd0;
            mem_we    <= winner ? p1_we    : p0_we;
            mem_addr  <= winner ? p1_addr  : p0_addr;
            mem_wdata <= winner ? p1_wdata : p0_wdata;
         end else if (state == WAIT) begin
            cnt <= cnt + 8'd1;
            if (complete || abort) begin
               mem_we <= 1'b0;
               prio   <= ~owner;
               if (owner) begin
                  p1_done <= 1'b1;
               end else begin
                  p0_done <= 1'b1;
               end
            end
            // mem_we still reflects the command being completed.
            if (complete && !mem_we) begin
               if (owner) begin
                  p1_rdata <= mem_rdata;
               end else begin
                  p0_rdata <= mem_rdata;
               end
            end
            if (abort) begin
               timeout_err <= 1'b1;
            end
         end else begin
            mem_we <= 1'b0;
         end
      end
   end

endmodule
